// File: rtl/mul_div_unit_pkg.sv
// Shared types and op-decode helpers for the integer multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned CORE_XLEN = 64;

    typedef logic [CORE_XLEN-1:0] data_t;

    typedef enum logic [3:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } mdu_op_enum;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} mdu_state_e;

    function automatic logic is_div_op(mdu_op_enum op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem_op(mdu_op_enum op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_word_op(mdu_op_enum op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    // Rs1 is treated as signed; rs2 is signed too except for MULHSU.
    function automatic logic is_signed_op(mdu_op_enum op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                          OP_MULW, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result handshake bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    mdu_op_enum      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;

    modport master (output in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, res);
    modport slave  (input  in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, res);
endinterface

// File: rtl/mul_div_unit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module mdu_div_step #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] divisor,
    input  logic         dvd_bit,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);
    logic [W:0]   shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        // rem_in < divisor, so a non-borrowing difference never sets bit W.
        q_bit   = ~|diff[W+1:W];
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV64 M-extension unit: shift-add multiply, restoring divide, sign fix-up.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned WORD = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mul_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_e        state, state_nx;
    mdu_op_enum        op_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q, dvd_q, rem_q, res_q;

    logic              in_ready_w, accept, word, sgn_a, sgn_b, a_neg, b_neg;
    logic              div_zero, div_ovf, special, neg;
    logic [XLEN-1:0]   a_op, b_op, a_ext, b_ext, mag_a, mag_b, special_res;
    logic [XLEN:0]     add_sum;
    logic [XLEN-1:0]   step_rem;
    logic              q_bit;
    logic              fix_word;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   raw, raw_neg, fix_v, fix_res;

    assign accept = bus.in_valid && in_ready_w;

    // Operand decode at accept: magnitudes, result sign and the no-iteration cases.
    always_comb begin
        word  = is_word_op(bus.op);
        sgn_a = is_signed_op(bus.op);
        sgn_b = sgn_a && (bus.op != OP_MULHSU);
        a_op  = word ? {{(XLEN-WORD){1'b0}}, bus.a[WORD-1:0]} : bus.a;
        b_op  = word ? {{(XLEN-WORD){1'b0}}, bus.b[WORD-1:0]} : bus.b;
        a_ext = word ? {{(XLEN-WORD){bus.a[WORD-1]}}, bus.a[WORD-1:0]} : bus.a;
        b_ext = word ? {{(XLEN-WORD){bus.b[WORD-1]}}, bus.b[WORD-1:0]} : bus.b;
        a_neg = sgn_a && a_ext[XLEN-1];
        b_neg = sgn_b && b_ext[XLEN-1];
        mag_a = a_neg ? -a_ext : a_op;
        mag_b = b_neg ? -b_ext : b_op;
        neg   = is_rem_op(bus.op) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div_op(bus.op) && (b_op == '0);
        div_ovf  = is_div_op(bus.op) && sgn_a && (b_ext == '1) &&
                   (a_ext == (word ? {{(XLEN-WORD+1){1'b1}}, {(WORD-1){1'b0}}}
                                   : {1'b1, {(XLEN-1){1'b0}}}));
        special  = div_zero || div_ovf;
        if (div_zero) special_res = is_rem_op(bus.op) ? a_ext : '1;
        else          special_res = is_rem_op(bus.op) ? '0 : a_ext;
    end

    assign add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .divisor (mag_b_q),
        .dvd_bit (dvd_q[XLEN-1]),
        .rem_out (step_rem),
        .q_bit   (q_bit)
    );

    // W multiplies finish after WORD shifts, leaving the product offset by XLEN-WORD.
    always_comb begin
        fix_word = is_word_op(op_q);
        prod_neg = neg_q ? -prod_q : prod_q;
        if (is_div_op(op_q)) raw = is_rem_op(op_q) ? rem_q : dvd_q;
        else                 raw = {{(XLEN-WORD){1'b0}}, prod_q[XLEN-WORD +: WORD]};
        raw_neg = neg_q ? -raw : raw;
        if (fix_word || is_div_op(op_q)) fix_v = raw_neg;
        else if (op_q == OP_MUL)         fix_v = prod_neg[XLEN-1:0];
        else                             fix_v = prod_neg[2*XLEN-1:XLEN];
        fix_res = fix_word ? {{(XLEN-WORD){fix_v[WORD-1]}}, fix_v[WORD-1:0]} : fix_v;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = special ? S_DONE : S_BUSY;
            S_BUSY: if (cnt_q == '0) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_comb begin
        in_ready_w    = (state == S_IDLE) && !flush;
        bus.in_ready  = in_ready_w;
        bus.out_valid = (state == S_DONE);
        bus.res       = res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    op_q    <= bus.op;
                    neg_q   <= neg;
                    cnt_q   <= CW'(word ? WORD - 1 : XLEN - 1);
                    mag_a_q <= mag_a;
                    mag_b_q <= mag_b;
                    prod_q  <= {{XLEN{1'b0}}, mag_b};
                    dvd_q   <= word ? (mag_a << (XLEN - WORD)) : mag_a;
                    rem_q   <= '0;
                    if (special) res_q <= special_res;
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div_op(op_q)) begin
                        dvd_q <= {dvd_q[XLEN-2:0], q_bit};
                        rem_q <= step_rem;
                    end else begin
                        prod_q <= {add_sum, prod_q[XLEN-1:1]};
                    end
                end
                S_FIX:   res_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule
